// File: rtl/uv_recon_ctrl.sv
// uv_recon_ctrl: raster-order macroblock scheduler for the chroma reconstruction datapath
// Ports: frame_start/mb_w/mb_h start a frame; src_valid/src_ready take MBs in;
// dp_start/dp_x/dp_y/dp_done/dp_nz drive the datapath; dp_derr, dp_left_derr and
// dp_top_derr(_en/_addr) carry diffusion error; res_* emit per-MB non-zero masks;
// busy/frame_done report frame progress.
// Define UV_RECON_DERR_EN to build the left register and top line buffer.
module uv_recon_ctrl #(
  parameter int MAX_MB_W = 64,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_start,
  input  logic [AW-1:0] mb_w,
  input  logic [AW-1:0] mb_h,
  input  logic          src_valid,
  output logic          src_ready,
  output logic          dp_start,
  output logic [AW-1:0] dp_x,
  output logic [AW-1:0] dp_y,
  input  logic          dp_done,
  input  logic [47:0]   dp_derr,
  input  logic [31:0]   dp_nz,
  input  logic          dp_top_derr_en,
  input  logic [AW-1:0] dp_top_derr_addr,
  output logic [31:0]   dp_left_derr,
  output logic [31:0]   dp_top_derr,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [31:0]   res_nz,
  output logic [AW-1:0] res_x,
  output logic [AW-1:0] res_y,
  output logic          busy,
  output logic          frame_done
);
  typedef enum logic [1:0] {IDLE, WAIT_SRC, RUN, EMIT} state_t;
  state_t        state_q;
  logic [AW-1:0] w_q, h_q, x_q, y_q, res_x_q, res_y_q;
  logic [31:0]   res_nz_q;
  logic          dp_start_q, frame_done_q;
  logic          last_col, last_row;
  assign last_col = x_q == w_q - AW'(1);
  assign last_row = y_q == h_q - AW'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q      <= IDLE;
      w_q          <= '0;
      h_q          <= '0;
      x_q          <= '0;
      y_q          <= '0;
      res_x_q      <= '0;
      res_y_q      <= '0;
      res_nz_q     <= '0;
      dp_start_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      dp_start_q   <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: if (frame_start) begin
          w_q <= mb_w;
          h_q <= mb_h;
          x_q <= '0;
          y_q <= '0;
          if (mb_w == '0 || mb_h == '0) frame_done_q <= 1'b1;
          else state_q <= WAIT_SRC;
        end
        WAIT_SRC: if (src_valid) begin
          dp_start_q <= 1'b1;
          state_q    <= RUN;
        end
        RUN: if (dp_done) begin
          res_nz_q <= dp_nz;
          res_x_q  <= x_q;
          res_y_q  <= y_q;
          state_q  <= EMIT;
        end
        EMIT: if (res_ready) begin
          x_q          <= last_col ? '0 : x_q + AW'(1);
          y_q          <= last_col ? y_q + AW'(1) : y_q;
          frame_done_q <= last_col && last_row;
          state_q      <= last_col && last_row ? IDLE : WAIT_SRC;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign src_ready  = state_q == WAIT_SRC;
  assign res_valid  = state_q == EMIT;
  assign busy       = state_q != IDLE;
  assign dp_start   = dp_start_q;
  assign frame_done = frame_done_q;
  assign dp_x       = x_q;
  assign dp_y       = y_q;
  assign res_nz     = res_nz_q;
  assign res_x      = res_x_q;
  assign res_y      = res_y_q;
`ifdef UV_RECON_DERR_EN
  localparam int MW = MAX_MB_W > 1 ? $clog2(MAX_MB_W) : 1;
  localparam logic [AW-1:0] MAXW = AW'(MAX_MB_W);
  logic [31:0] top_mem [MAX_MB_W];
  logic [31:0] left_q, top_q, top_wd;
  logic        top_we;
  assign top_we = state_q == RUN && dp_done;
  assign top_wd = {dp_derr[47:32], dp_derr[23:8]};
  always_ff @(posedge clk)
    if (top_we && x_q < MAXW) top_mem[x_q[MW-1:0]] <= top_wd;
  // Row 0 has no row above, so stale buffer contents are masked rather than cleared.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      left_q <= '0;
      top_q  <= '0;
    end else begin
      if ((state_q == IDLE && frame_start) || (state_q == EMIT && res_ready && last_col)) left_q <= '0;
      else if (top_we) left_q <= {dp_derr[39:24], dp_derr[15:0]};
      if (dp_top_derr_en)
        top_q <= (y_q == '0 || dp_top_derr_addr >= w_q || dp_top_derr_addr >= MAXW) ? '0 :
                 (top_we && dp_top_derr_addr == x_q) ? top_wd : top_mem[dp_top_derr_addr[MW-1:0]];
    end
  assign dp_left_derr = x_q == '0 ? '0 : left_q;
  assign dp_top_derr  = top_q;
`else
  logic unused_derr;
  assign unused_derr  = ^{dp_derr, dp_top_derr_en, dp_top_derr_addr, MAX_MB_W > 0};
  assign dp_left_derr = '0;
  assign dp_top_derr  = '0;
`endif
endmodule
